// File: rtl/nv_ram_fifo_ctrl_80x65.sv
// 80x65 FIFO controller in front of a single-port-pair RAM with a 4-entry output buffer.
// Define NV_RAM_FIFO_CTRL_STATUS_EN to add the fifo_count / wr_afull status outputs.
module nv_ram_fifo_ctrl_80x65 #(
    parameter int AFULL_LVL = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [64:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [64:0] rd_pd,
    output logic        ram_we,
    output logic [6:0]  ram_wa,
    output logic [64:0] ram_di,
    output logic        ram_re,
    output logic [6:0]  ram_ra,
    output logic        ram_ore,
    input  logic [64:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_pd
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    ,
    output logic [6:0]  fifo_count,
    output logic        wr_afull
`endif
);

    if (AFULL_LVL < 1 || AFULL_LVL > 80) begin : g_bad_afull
        $error("AFULL_LVL must be within 1..80");
    end

    localparam logic [6:0] LP_DEPTH = 7'd80;
    localparam logic [6:0] LP_LAST  = 7'd79;

    logic [6:0]  r_wr_ptr;
    logic [6:0]  r_rd_ptr;
    logic [6:0]  r_ram_cnt;
    logic [6:0]  r_total;
    logic        r_ore;
    logic        r_cap;
    logic [64:0] r_obuf [4];
    logic [1:0]  r_ob_wp;
    logic [1:0]  r_ob_rp;
    logic [2:0]  r_ob_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_re;
    logic [2:0]  w_occ;
    logic [6:0]  w_total_nxt;

    // Slots past the RAM: reads in the ore/capture stages plus buffered beats.
    assign w_occ       = r_ob_cnt + 3'(r_ore) + 3'(r_cap);
    assign wr_prdy     = !rst && (r_total < LP_DEPTH);
    assign rd_pvld     = (r_ob_cnt != 3'd0);
    assign w_push      = wr_pvld && wr_prdy;
    assign w_pop       = rd_pvld && rd_prdy;
    assign w_re        = (r_ram_cnt != 7'd0) &&
                         ((w_occ < 3'd4) || ((w_occ == 3'd4) && w_pop));
    assign w_total_nxt = r_total + 7'(w_push) - 7'(w_pop);

    assign rd_pd         = rd_pvld ? r_obuf[r_ob_rp] : '0;
    assign ram_we        = w_push;
    assign ram_wa        = r_wr_ptr;
    assign ram_di        = wr_pd;
    assign ram_re        = w_re;
    assign ram_ra        = r_rd_ptr;
    assign ram_ore       = r_ore;
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_total   <= '0;
            r_ore     <= 1'b0;
            r_cap     <= 1'b0;
            r_ob_wp   <= '0;
            r_ob_rp   <= '0;
            r_ob_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? 7'd0 : r_wr_ptr + 7'd1;
            end
            if (w_re) begin
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? 7'd0 : r_rd_ptr + 7'd1;
            end
            r_ram_cnt <= r_ram_cnt + 7'(w_push) - 7'(w_re);
            r_total   <= w_total_nxt;
            r_ore     <= w_re;
            r_cap     <= r_ore;
            if (r_cap) begin
                r_ob_wp <= r_ob_wp + 2'd1;
            end
            if (w_pop) begin
                r_ob_rp <= r_ob_rp + 2'd1;
            end
            r_ob_cnt <= r_ob_cnt + 3'(r_cap) - 3'(w_pop);
        end
    end

    // RAM output is valid the cycle after ore; capture it into the buffer tail.
    always_ff @(posedge clk) begin
        if (r_cap) begin
            r_obuf[r_ob_wp] <= ram_dout;
        end
    end

`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    logic r_afull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_total_nxt >= 7'(AFULL_LVL));
        end
    end

    assign fifo_count = r_total;
    assign wr_afull   = r_afull;
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x65.sv
// Randomised bench for nv_ram_fifo_ctrl_80x65 with a queue reference model and RAM model.
// Status outputs are checked when NV_RAM_FIFO_CTRL_STATUS_EN is defined.
module tb_nv_ram_fifo_ctrl_80x65;

    localparam int AFULL = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        wr_prdy;
    logic [64:0] wr_pd = '0;
    logic        rd_pvld;
    logic        rd_prdy = 1'b0;
    logic [64:0] rd_pd;
    logic        ram_we;
    logic [6:0]  ram_wa;
    logic [64:0] ram_di;
    logic        ram_re;
    logic [6:0]  ram_ra;
    logic        ram_ore;
    logic [64:0] ram_dout;
    logic [31:0] pwrbus_ram_pd = 32'hA5C3_0F19;
    logic [31:0] ram_pwrbus_pd;
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    logic [6:0]  fifo_count;
    logic        wr_afull;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_80x65 #(.AFULL_LVL(AFULL)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .ram_we        (ram_we),
        .ram_wa        (ram_wa),
        .ram_di        (ram_di),
        .ram_re        (ram_re),
        .ram_ra        (ram_ra),
        .ram_ore       (ram_ore),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .ram_pwrbus_pd (ram_pwrbus_pd)
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        ,
        .fifo_count    (fifo_count),
        .wr_afull      (wr_afull)
`endif
    );

    // RAM model: synchronous write, address registered on re, data registered on ore.
    logic [64:0] mem [80];
    logic [6:0]  ra_q = '0;
    logic [64:0] dout_q = '0;
    assign ram_dout = dout_q;

    always @(posedge clk) begin
        if (ram_we && ram_wa < 7'd80) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore && ra_q < 7'd80) dout_q <= mem[ra_q];
    end

    // Reference model: the FIFO is a queue of accepted words; occupancy is its size.
    logic [64:0] q[$];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          tot_push = 0;
    int          tot_pop = 0;
    bit          prev_stall = 0;
    logic [64:0] prev_pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            wr_idx = 0;
            rd_idx = 0;
            prev_stall = 0;
        end else begin
            n_cmp++;
            if (wr_prdy !== (q.size() < 80)) begin
                n_err++;
                $display("FAIL sb_wr_prdy: got %b want %b (occ %0d)",
                         wr_prdy, q.size() < 80, q.size());
            end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
            n_cmp++;
            if (fifo_count !== 7'(q.size()) || wr_afull !== (q.size() >= AFULL)) begin
                n_err++;
                $display("FAIL sb_status: got count %0d afull %b want %0d %b",
                         fifo_count, wr_afull, q.size(), q.size() >= AFULL);
            end
`endif
            if (prev_stall) begin
                n_cmp++;
                if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin
                    n_err++;
                    $display("FAIL sb_stall_hold: got v%b %h want v1 %h",
                             rd_pvld, rd_pd, prev_pd);
                end
            end
            if (ram_we) begin
                n_cmp++;
                if (ram_wa !== 7'(wr_idx % 80)) begin
                    n_err++;
                    $display("FAIL sb_ram_wa: got %0d want %0d", ram_wa, wr_idx % 80);
                end
                wr_idx++;
            end
            if (ram_re) begin
                n_cmp++;
                if (ram_ra !== 7'(rd_idx % 80)) begin
                    n_err++;
                    $display("FAIL sb_ram_ra: got %0d want %0d", ram_ra, rd_idx % 80);
                end
                rd_idx++;
            end
            if (rd_pvld === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_stale: got rd_pvld 1 data %h want empty", rd_pd);
                end else if (rd_pd !== q[0]) begin
                    n_err++;
                    $display("FAIL sb_data: got %h want %h", rd_pd, q[0]);
                end
                if (rd_prdy && q.size() != 0) begin
                    void'(q.pop_front());
                    tot_pop++;
                end
            end
            if (wr_pvld && wr_prdy) begin
                q.push_back(wr_pd);
                tot_push++;
            end
            prev_stall = rd_pvld && !rd_prdy;
            prev_pd    = rd_pd;
        end
    end

    function automatic logic [64:0] rnd();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    task automatic drain();
        int idle = 0;
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rd_pvld) idle = 0;
            else idle++;
            if (idle >= 8) break;
        end
        #1;
        n_cmp++;
        if (idle < 8 || q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got idle %0d left %0d want idle 8 left 0", idle, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        wr_pd = rnd();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_prdy, rd_pvld, ram_we, ram_re, ram_ore} !== 5'b0 || rd_pd !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %b pd %h want 00000 pd 0",
                     {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore}, rd_pd);
        end
        n_cmp++;
        if (ram_pwrbus_pd !== pwrbus_ram_pd) begin
            n_err++;
            $display("FAIL pwrbus: got %h want %h", ram_pwrbus_pd, pwrbus_ram_pd);
        end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        n_cmp++;
        if (fifo_count !== 7'd0 || wr_afull !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: got %0d %b want 0 0", fifo_count, wr_afull);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        wr_pvld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_prdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got wr_prdy %b want 1", wr_prdy);
        end
    endtask

    task automatic test_single();
        logic [64:0] d;
        d = 65'h1_2345_6789_ABCD_EF01;
        @(posedge clk); #1;
        wr_pvld = 1'b1;
        wr_pd = d;
        rd_prdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ram_we !== 1'b1 || ram_di !== d || ram_wa !== 7'd0) begin
            n_err++;
            $display("FAIL single_write: got we %b wa %0d di %h want 1 0 %h",
                     ram_we, ram_wa, ram_di, d);
        end
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_pvld !== (k == 4) || ram_re !== (k == 1) || ram_ore !== (k == 2)) begin
                n_err++;
                $display("FAIL single_latency t+%0d: got v%b re%b ore%b", k, rd_pvld, ram_re, ram_ore);
            end
            if (k == 4) begin
                n_cmp++;
                if (rd_pd !== d) begin
                    n_err++;
                    $display("FAIL single_data: got %h want %h", rd_pd, d);
                end
            end
        end
        drain();
    endtask

    task automatic test_fill();
        rd_prdy = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            wr_pvld = 1'b1;
            wr_pd = rnd();
            @(negedge clk);
            n_cmp++;
            if (wr_prdy !== 1'b1) begin
                n_err++;
                $display("FAIL fill_ready: entry %0d got %b want 1", i, wr_prdy);
            end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
            n_cmp++;
            if (wr_afull !== (i >= AFULL)) begin
                n_err++;
                $display("FAIL fill_afull: count %0d got %b want %b", i, wr_afull, i >= AFULL);
            end
`endif
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr_pd = rnd();
            @(negedge clk);
            n_cmp++;
            if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || rd_pvld !== 1'b1) begin
                n_err++;
                $display("FAIL full_block: got prdy %b we %b pvld %b want 0 0 1",
                         wr_prdy, ram_we, rd_pvld);
            end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
            n_cmp++;
            if (fifo_count !== 7'd80 || wr_afull !== 1'b1) begin
                n_err++;
                $display("FAIL full_status: got %0d %b want 80 1", fifo_count, wr_afull);
            end
`endif
        end
    endtask

    task automatic test_full_pop();
        @(posedge clk); #1;
        wr_pvld = 1'b1;
        wr_pd = rnd();
        rd_prdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || rd_pvld !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_same: got prdy %b we %b pvld %b want 0 0 1",
                     wr_prdy, ram_we, rd_pvld);
        end
        @(posedge clk); #1;
        rd_prdy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_prdy !== 1'b1 || ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_next: got prdy %b we %b want 1 1", wr_prdy, ram_we);
        end
        drain();
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, first = -1, gaps = 0, wstall = 0;
        rd_prdy = 1'b1;
        for (int c = 0; c < 400 && got < 200; c++) begin
            @(posedge clk); #1;
            wr_pvld = (sent < 200);
            wr_pd = rnd();
            @(negedge clk);
            if (wr_pvld) begin
                if (wr_prdy) sent++;
                else wstall++;
            end
            if (rd_pvld) begin
                got++;
                if (first < 0) first = c;
            end else if (first >= 0) begin
                gaps++;
            end
        end
        n_cmp++;
        if (first != 4 || gaps != 0 || got != 200 || wstall != 0) begin
            n_err++;
            $display("FAIL stream: got first %0d gaps %0d beats %0d wstall %0d want 4 0 200 0",
                     first, gaps, got, wstall);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int p0, s = 0;
        p0 = tot_push;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            wr_pvld = ($urandom_range(9, 0) < 7);
            wr_pd = rnd();
            rd_prdy = $urandom_range(1, 0) == 1;
            @(negedge clk);
            if (rd_pvld && !rd_prdy) s++;
        end
        drain();
        n_cmp++;
        if (tot_push - p0 < 100 || s < 20 || tot_pop != tot_push) begin
            n_err++;
            $display("FAIL backpressure: got pushed %0d stalls %0d pops %0d want pops %0d",
                     tot_push - p0, s, tot_pop, tot_push);
        end
    endtask

    task automatic test_reset_mid();
        rd_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            wr_pvld = 1'b1;
            wr_pd = rnd();
        end
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        repeat (6) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            wr_pvld = 1'b1;
            wr_pd = rnd();
            rd_prdy = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if (ram_re !== 1'b1 || ram_ore !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_inflight: got re %b ore %b want 1 1", ram_re, ram_ore);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        #1;
        n_cmp++;
        if (rd_pvld !== 1'b0 || wr_prdy !== 1'b0 || ram_ore !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: got pvld %b prdy %b ore %b want 0 0 0",
                     rd_pvld, wr_prdy, ram_ore);
        end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        n_cmp++;
        if (fifo_count !== 7'd0) begin
            n_err++;
            $display("FAIL midrst_count: got %0d want 0", fifo_count);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_prdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_pvld !== 1'b0 || ram_ore !== 1'b0 || wr_prdy !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_clean t%0d: got pvld %b ore %b prdy %b want 0 0 1",
                         k, rd_pvld, ram_ore, wr_prdy);
            end
        end
        @(posedge clk); #1;
        wr_pvld = 1'b1;
        wr_pd = rnd();
        @(posedge clk); #1;
        wr_pvld = 1'b0;
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nv_ram_fifo_ctrl_80x65.md
NV_RAM_FIFO_CTRL_80X65 -- requirements
Module: nv_ram_fifo_ctrl_80x65

Interface
REQ-001 SHALL have parameter AFULL_LVL, default 72, almost-full threshold in entries (1..80); used only with NV_RAM_FIFO_CTRL_STATUS_EN.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_pvld  input  1  write request valid.
REQ-005 SHALL have port wr_prdy  output  1  write ready.
REQ-006 SHALL have port wr_pd  input  65  write payload.
REQ-007 SHALL have port rd_pvld  output  1  read data valid.
REQ-008 SHALL have port rd_prdy  input  1  read consumer ready.
REQ-009 SHALL have port rd_pd  output  65  read payload.
REQ-010 SHALL have ports ram_we output 1, ram_wa output 7, ram_di output 65, ram_re output 1, ram_ra output 7, ram_ore output 1, ram_dout input 65: drive one 80x65 RAM (write same edge; ra registered on re; output registered on ore).
REQ-011 SHALL have port pwrbus_ram_pd  input  32  passed unchanged to output ram_pwrbus_pd (32).
REQ-012 SHALL, with NV_RAM_FIFO_CTRL_STATUS_EN, add fifo_count output 7 and wr_afull output 1.

Function
REQ-013 SHALL accept a write when wr_pvld && wr_prdy; same cycle ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd.
REQ-014 SHALL hold wr_prdy = (total < 80), total = ram_cnt + inflight + obuf_cnt, from registered state only (a pop in the same cycle does not free a slot for a write when full).
REQ-015 SHALL wrap wr_ptr and rd_ptr 79 -> 0; pointers never hold 80..127.
REQ-016 SHALL issue a read (ram_re=1, ram_ra=rd_ptr, rd_ptr++) when ram_cnt>0 and (inflight+obuf_cnt) < 4, or ==4 with a pop this cycle.
REQ-017 SHALL assert ram_ore exactly one cycle after each issued read; ram_dout captured into obuf the following cycle.
REQ-018 SHALL provide a 4-entry output buffer; rd_pvld = obuf_cnt>0; rd_pd = obuf head; pop on rd_pvld && rd_prdy.
REQ-019 SHALL give write-accept-to-rd_pvld latency of 4 cycles on an empty FIFO (accept T, re T+1, ore T+2, capture end T+3, rd_pvld T+4).
REQ-020 SHALL sustain one write and one pop per cycle in steady state, preserving FIFO order.
REQ-021 SHALL allow a write and a read issue in one cycle; write to a just-written entry becomes readable at the next cycle.
REQ-022 SHALL keep rd_pd stable while rd_pvld && !rd_prdy.
REQ-023 SHALL ignore wr_pvld when wr_prdy=0 and rd_prdy when rd_pvld=0 (no state change).

Reset
REQ-024 SHALL, while rst=1, force wr_ptr=0, rd_ptr=0, counts=0, obuf empty, in-flight pipeline cleared.
REQ-025 SHALL drive during reset: wr_prdy=0, rd_pvld=0, ram_we=0, ram_re=0, ram_ore=0; rd_pd=0.
REQ-026 SHALL drive wr_prdy=1 the first cycle after rst deasserts; reset mid-operation discards all content.

Configuration
REQ-027 SHALL, with NV_RAM_FIFO_CTRL_STATUS_EN defined, output fifo_count=total (0..80) and wr_afull=(total >= AFULL_LVL), both registered, 0 in reset.
REQ-028 SHALL, without NV_RAM_FIFO_CTRL_STATUS_EN, omit fifo_count and wr_afull ports and logic; all else identical.

Verification
REQ-029 SHALL test single write 0x1_2345_6789_ABCD_EF01 into empty FIFO, rd_prdy=1 -> rd_pvld at accept+4, rd_pd matches, one beat.
REQ-030 SHALL test 80 writes, rd_prdy=0 -> wr_prdy=0 after 80th accept; 81st wr_pvld ignored; fifo_count=80, wr_afull=1 from count 72.
REQ-031 SHALL test full FIFO, wr_pvld=1 and pop same cycle -> write not accepted that cycle, accepted next cycle.
REQ-032 SHALL test 200 streaming writes/reads with rd_prdy=1 -> 1 beat/cycle after fill, in-order data, pointers wrap 79->0 twice.
REQ-033 SHALL test random rd_prdy backpressure (50%) -> no loss/duplication, rd_pd stable during stall.
REQ-034 SHALL test rst asserted with 10 entries and 2 reads in flight -> rd_pvld=0 immediately, fifo_count=0, no stale data after release.
